// File: rtl/disparity_search_ctrl_if.sv
// Handshake bundle between the disparity search controller and its neighbours:
// search request, candidate issue, SAD return and best-match result.
interface disparity_search_ctrl_if #(
  parameter int unsigned DISP_W = 6,
  parameter int unsigned SAD_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              cand_valid;
  logic [DISP_W-1:0] disp_idx;
  logic              sad_valid;
  logic [SAD_W-1:0]  sad;
  logic              out_valid;
  logic              out_ready;
  logic [DISP_W-1:0] best_disp;
  logic [SAD_W-1:0]  best_sad;
  logic              err;

  // Environment side: front end, SAD datapath and disparity-map writer.
  modport master (
    output req_valid, sad_valid, sad, out_ready,
    input  req_ready, cand_valid, disp_idx, out_valid, best_disp, best_sad, err
  );

  // Controller side.
  modport slave (
    input  req_valid, sad_valid, sad, out_ready,
    output req_ready, cand_valid, disp_idx, out_valid, best_disp, best_sad, err
  );
endinterface

// File: rtl/disparity_search_ctrl.sv
// Sweeps candidate disparities 0..MAX_DISP-1 through one SAD unit and keeps the minimum.
// Optional macro DISP_TIE_FAR_EN: ties resolve to the larger disparity.
module disparity_search_ctrl #(
  parameter int unsigned MAX_DISP = 64,
  parameter int unsigned DISP_W   = 6,
  parameter int unsigned SAD_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  disparity_search_ctrl_if.slave bus
);

  localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(MAX_DISP - 1);
  localparam logic [SAD_W-1:0]  SAD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DISP_W-1:0] issue_cnt, issue_cnt_nxt;
  logic [DISP_W-1:0] rcv_cnt, rcv_cnt_nxt;
  logic [DISP_W-1:0] best, best_nxt;
  logic [SAD_W-1:0]  min_sad, min_sad_nxt;
  logic              err_flag, err_nxt;
  logic              req_ready_r, cand_valid_r, out_valid_r;
  logic              better;

  // State and datapath registers; status outputs are flopped from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      rcv_cnt      <= '0;
      best         <= '0;
      min_sad      <= SAD_MAX;
      err_flag     <= 1'b0;
      req_ready_r  <= 1'b1;
      cand_valid_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state        <= state_nxt;
      issue_cnt    <= issue_cnt_nxt;
      rcv_cnt      <= rcv_cnt_nxt;
      best         <= best_nxt;
      min_sad      <= min_sad_nxt;
      err_flag     <= err_nxt;
      req_ready_r  <= (state_nxt == IDLE);
      cand_valid_r <= (state_nxt == ISSUE);
      out_valid_r  <= (state_nxt == DONE);
    end
  end

  // Next-state, candidate sequencing and running-minimum update.
  always_comb begin
    state_nxt     = state;
    issue_cnt_nxt = issue_cnt;
    rcv_cnt_nxt   = rcv_cnt;
    best_nxt      = best;
    min_sad_nxt   = min_sad;
    err_nxt       = err_flag;
`ifdef DISP_TIE_FAR_EN
    better        = (bus.sad <= min_sad);
`else
    better        = (bus.sad < min_sad);
`endif

    case (state)
      IDLE: begin
        if (bus.sad_valid) err_nxt = 1'b1;
        if (bus.req_valid) begin
          state_nxt     = ISSUE;
          issue_cnt_nxt = '0;
          rcv_cnt_nxt   = '0;
          min_sad_nxt   = SAD_MAX;
          best_nxt      = '0;
        end
      end
      ISSUE, DRAIN: begin
        if (state == ISSUE) begin
          if (issue_cnt == LAST_IDX) state_nxt = DRAIN;
          else                       issue_cnt_nxt = issue_cnt + DISP_W'(1);
        end
        // Last result wins over the ISSUE->DRAIN move (zero-latency SAD).
        if (bus.sad_valid) begin
          if (better) begin
            min_sad_nxt = bus.sad;
            best_nxt    = rcv_cnt;
          end
          rcv_cnt_nxt = rcv_cnt + DISP_W'(1);
          if (rcv_cnt == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.sad_valid) err_nxt = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // disp_idx reads zero whenever no candidate is being issued.
    if (state_nxt != ISSUE) issue_cnt_nxt = '0;
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.cand_valid = cand_valid_r;
  assign bus.disp_idx   = issue_cnt;
  assign bus.out_valid  = out_valid_r;
  assign bus.best_disp  = best;
  assign bus.best_sad   = min_sad;
  assign bus.err        = err_flag;

endmodule

// File: tb/tb_disparity_search_ctrl.sv
// Randomized self-checking bench for disparity_search_ctrl with an array-based
// reference (minimum value, then first/last index holding it) and a latency-L SAD responder.
module tb_disparity_search_ctrl;

  localparam int unsigned MAX_DISP = 8;
  localparam int unsigned DISP_W   = 3;
  localparam int unsigned SAD_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int vals [MAX_DISP];
  int hv [16];
  int hi [16];

  disparity_search_ctrl_if #(.DISP_W(DISP_W), .SAD_W(SAD_W)) bus ();

  disparity_search_ctrl #(
    .MAX_DISP(MAX_DISP),
    .DISP_W  (DISP_W),
    .SAD_W   (SAD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_min();
    int m = (1 << SAD_W) - 1;
    for (int i = 0; i < int'(MAX_DISP); i++) if (vals[i] < m) m = vals[i];
    return m;
  endfunction

  // Index of the minimum: first occurrence normally, last one with far-tie rule.
  function automatic int ref_best(input int m);
    int b = -1;
    for (int i = 0; i < int'(MAX_DISP); i++) begin
      if (vals[i] == m) begin
`ifdef DISP_TIE_FAR_EN
        b = i;
`else
        if (b < 0) b = i;
`endif
      end
    end
    return b;
  endfunction

  task automatic clear_pipe();
    for (int i = 0; i < 16; i++) begin
      hv[i] = 0;
      hi[i] = 0;
    end
  endtask

  // SAD unit model: result for a candidate seen now comes back lat cycles later.
  task automatic respond(input int lat);
    for (int i = 15; i > 0; i--) begin
      hv[i] = hv[i-1];
      hi[i] = hi[i-1];
    end
    hv[0] = int'(bus.cand_valid);
    hi[0] = int'(bus.disp_idx);
    bus.sad_valid = (hv[lat] != 0);
    bus.sad       = (hv[lat] != 0) ? SAD_W'(vals[hi[lat]]) : '0;
  endtask

  task automatic run_search(input int lat, input int hold, input int exp_err);
    int k;
    int ov_at;
    int m;
    int eb;
    m = ref_min();
    eb = ref_best(m);
    check("req_ready_pre", 32'(bus.req_ready), 32'd1);
    clear_pipe();
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    k = 1;
    ov_at = 0;
    while (k < 60) begin
      if (bus.out_valid) begin
        ov_at = k;
        break;
      end
      check("cand_valid", 32'(bus.cand_valid), 32'(k <= int'(MAX_DISP)));
      if (k <= int'(MAX_DISP)) check("disp_idx", 32'(bus.disp_idx), 32'(k - 1));
      respond(lat);
      tick();
      k++;
    end
    bus.sad_valid = 1'b0;
    check("out_valid_cycle", 32'(ov_at), 32'(int'(MAX_DISP) + lat + 1));
    check("best_disp", 32'(bus.best_disp), 32'(eb));
    check("best_sad", 32'(bus.best_sad), 32'(m));
    check("req_ready_done", 32'(bus.req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_best_disp", 32'(bus.best_disp), 32'(eb));
      check("hold_best_sad", 32'(bus.best_sad), 32'(m));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
    check("err_state", 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad       = '0;
    bus.out_ready = 1'b0;
    clear_pipe();

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_cand_valid", 32'(bus.cand_valid), 32'd0);
    check("rst_disp_idx", 32'(bus.disp_idx), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_best_disp", 32'(bus.best_disp), 32'd0);
    check("rst_best_sad", 32'(bus.best_sad), 32'd255);
    check("rst_err", 32'(bus.err), 32'd0);
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Directed cases
    vals = '{50, 40, 30, 30, 60, 70, 80, 90};
    run_search(0, 0, 0);
    vals = '{20, 30, 40, 50, 60, 70, 80, 5};
    run_search(3, 0, 0);
    vals = '{255, 255, 255, 255, 255, 255, 255, 255};
    run_search(1, 0, 0);

    // Stalled result then back-to-back request
    for (int i = 0; i < int'(MAX_DISP); i++) vals[i] = int'($urandom_range(0, 255));
    run_search(2, 10, 0);
    for (int i = 0; i < int'(MAX_DISP); i++) vals[i] = int'($urandom_range(0, 255));
    run_search(0, 0, 0);

    // Randomized searches, half with narrow value ranges to force ties
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < int'(MAX_DISP); i++)
        vals[i] = (n % 2 == 1) ? int'($urandom_range(10, 12)) : int'($urandom_range(0, 255));
      run_search(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0);
    end

    // Abort on the 4th issue cycle
    for (int i = 0; i < int'(MAX_DISP); i++) vals[i] = int'($urandom_range(0, 255));
    clear_pipe();
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      respond(0);
      tick();
    end
    check("abort_cand_valid_pre", 32'(bus.cand_valid), 32'd1);
    respond(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.sad_valid = 1'b0;
    check("abort_cand_valid", 32'(bus.cand_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_err", 32'(bus.err), 32'd0);

    // Late results after the abort flag a protocol error
    bus.sad_valid = 1'b1;
    bus.sad = 8'd7;
    tick();
    tick();
    bus.sad_valid = 1'b0;
    check("late_err", 32'(bus.err), 32'd1);
    check("late_best_sad", 32'(bus.best_sad), 32'd255);
    tick();
    tick();
    check("late_err_sticky", 32'(bus.err), 32'd1);

    for (int i = 0; i < int'(MAX_DISP); i++) vals[i] = int'($urandom_range(0, 255));
    run_search(1, 2, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", 32'(bus.err), 32'd0);
    tick();
    vals = '{9, 9, 3, 8, 3, 7, 6, 5};
    run_search(4, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
